branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 38 +++
 rtl/branch_resolver_ras.sv | 57 +++++
 rtl/branch_resolver.sv | 179 +++++++++++++++++
 tb/tb_branch_resolver.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// Shared branch-mode encoding and registered result fields for the branch resolver.
// The four link modes are appended after the original mode list so that existing
// encodings keep their values.
package BranchModesPackage;

    typedef enum logic [3:0] {
        BranchMode_NONE   = 4'd0,
        BranchMode_BEQ    = 4'd1,
        BranchMode_BNE    = 4'd2,
        BranchMode_BGEZ   = 4'd3,
        BranchMode_BGTZ   = 4'd4,
        BranchMode_BLEZ   = 4'd5,
        BranchMode_BLTZ   = 4'd6,
        BranchMode_J      = 4'd7,
        BranchMode_JR     = 4'd8,
        BranchMode_JAL    = 4'd9,
        BranchMode_JALR   = 4'd10,
        BranchMode_BGEZAL = 4'd11,
        BranchMode_BLTZAL = 4'd12
    } BranchMode;

    // Single-bit registered outputs. The address outputs follow the instance
    // ADDR_W parameter, so they are registered beside this struct.
    typedef struct packed {
        logic shouldUseNewPC;
        logic linkValid;
        logic rasMatch;
        logic rasOverflow;
        logic rasUnderflow;
    } branch_result_t;

    // Modes that write a return address to the register file.
    function automatic logic isLinkMode(input BranchMode m);
        return (m == BranchMode_JAL) || (m == BranchMode_JALR) ||
               (m == BranchMode_BGEZAL) || (m == BranchMode_BLTZAL);
    endfunction

endpackage

// File: rtl/branch_resolver_ras.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry while the count saturates; a pop from an empty stack does nothing.
// Push and pop are never requested together by the resolver.
module branch_ras
    import BranchModesPackage::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_pushData,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [PTR_W:0]    r_count;
    logic [PTR_W-1:0]  w_topIdx;

    // The pointer addresses the next free slot, so the top lives one below it.
    assign w_topIdx    = r_ptr - PTR_W'(1);
    assign o_top       = r_mem[w_topIdx];
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == (PTR_W+1)'(RAS_DEPTH));
    assign o_overflow  = i_push && o_full;
    assign o_underflow = i_pop && o_empty;

    // Stack storage, write pointer and occupancy update.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_ptr] <= i_pushData;
            r_ptr        <= r_ptr + PTR_W'(1);
            if (!o_full) begin
                r_count <= r_count + (PTR_W+1)'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_ptr   <= w_topIdx;
            r_count <= r_count - (PTR_W+1)'(1);
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: evaluates branch/jump conditions and targets, produces the
// link write and a registered result behind a valid/ready handshake.
// Optional macro BRANCH_RESOLVER_RAS_EN adds a return-address stack that
// predicts JR targets; without it the RAS status outputs are constant 0.
module branch_resolver
    import BranchModesPackage::*;
#(
    parameter int ADDR_W    = 32,
    parameter int OFFSET_W  = 16,
    parameter int JUMP_W    = 26,
    parameter int RAS_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3:0]          mode,
    input  logic [ADDR_W-1:0]   pcAddress,
    input  logic [OFFSET_W-1:0] branchAddressOffset,
    input  logic [JUMP_W-1:0]   jumpAddress,
    input  logic [ADDR_W-1:0]   jumpRegisterAddress,
    input  logic                resultZero,
    input  logic                resultNegative,
    input  logic                resultPositive,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                shouldUseNewPC,
    output logic [ADDR_W-1:0]   branchTo,
    output logic                linkValid,
    output logic [ADDR_W-1:0]   linkAddress,
    output logic                rasMatch,
    output logic                rasOverflow,
    output logic                rasUnderflow
);

    BranchMode        w_mode;
    logic             w_accept;
    logic             w_taken;
    logic             w_isLink;
    logic [ADDR_W-1:0] w_offsetExt;
    logic [ADDR_W-1:0] w_condTarget;
    logic [ADDR_W-1:0] w_jumpTarget;
    logic [ADDR_W-1:0] w_rawTarget;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_link;
    logic             w_rasMatch;
    logic             w_rasOverflow;
    logic             w_rasUnderflow;
    branch_result_t   w_next;

    logic             r_valid;
    branch_result_t   r_result;
    logic [ADDR_W-1:0] r_branchTo;
    logic [ADDR_W-1:0] r_linkAddress;

    assign w_mode   = BranchMode'(mode);
    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Word offset is sign-extended (or truncated) to the address width, then scaled.
    assign w_offsetExt  = ADDR_W'($signed(branchAddressOffset));
    assign w_condTarget = pcAddress + (w_offsetExt << 2);
    assign w_jumpTarget = {pcAddress[ADDR_W-1 -: 4], (ADDR_W-6)'(jumpAddress), 2'b00};

    // Condition evaluation and target-source selection per mode.
    always_comb begin
        w_taken     = 1'b0;
        w_rawTarget = w_condTarget;
        case (w_mode)
            BranchMode_BEQ:    w_taken = resultZero;
            BranchMode_BNE:    w_taken = !resultZero;
            BranchMode_BGEZ,
            BranchMode_BGEZAL: w_taken = resultZero || resultPositive;
            BranchMode_BGTZ:   w_taken = resultPositive;
            BranchMode_BLEZ:   w_taken = resultZero || resultNegative;
            BranchMode_BLTZ,
            BranchMode_BLTZAL: w_taken = resultNegative;
            BranchMode_J,
            BranchMode_JAL: begin
                w_taken     = 1'b1;
                w_rawTarget = w_jumpTarget;
            end
            BranchMode_JR,
            BranchMode_JALR: begin
                w_taken     = 1'b1;
                w_rawTarget = jumpRegisterAddress;
            end
            default:           w_taken = 1'b0;
        endcase
    end

    assign w_isLink = isLinkMode(w_mode);
    assign w_target = w_taken ? w_rawTarget : '0;
    assign w_link   = w_isLink ? (pcAddress + ADDR_W'(8)) : '0;

`ifdef BRANCH_RESOLVER_RAS_EN
    logic              w_rasPush;
    logic              w_rasPop;
    logic [ADDR_W-1:0] w_rasTop;
    logic              w_rasEmpty;
    logic              w_rasFull;
    logic              w_rasOvfPulse;
    logic              w_rasUnfPulse;

    // Only accepted requests touch the stack, so a flush cycle leaves it intact.
    assign w_rasPush = w_accept && w_isLink;
    assign w_rasPop  = w_accept && (w_mode == BranchMode_JR);

    branch_ras #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_push      (w_rasPush),
        .i_pop       (w_rasPop),
        .i_pushData  (w_link),
        .o_top       (w_rasTop),
        .o_empty     (w_rasEmpty),
        .o_full      (w_rasFull),
        .o_overflow  (w_rasOvfPulse),
        .o_underflow (w_rasUnfPulse)
    );

    assign w_rasMatch     = w_rasPop && !w_rasEmpty && (w_rasTop == jumpRegisterAddress);
    assign w_rasOverflow  = w_rasOvfPulse && w_rasFull;
    assign w_rasUnderflow = w_rasUnfPulse;
`else
    assign w_rasMatch     = 1'b0;
    assign w_rasOverflow  = 1'b0;
    assign w_rasUnderflow = 1'b0;
`endif

    // Collect the single-bit result fields for the output register.
    always_comb begin
        w_next                = '0;
        w_next.shouldUseNewPC = w_taken;
        w_next.linkValid      = w_isLink;
        w_next.rasMatch       = w_rasMatch;
        w_next.rasOverflow    = w_rasOverflow;
        w_next.rasUnderflow   = w_rasUnderflow;
    end

    // Output register: flush wins, then a new acceptance, then hand-off clears.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid       <= 1'b0;
            r_result      <= '0;
            r_branchTo    <= '0;
            r_linkAddress <= '0;
        end else if (flush) begin
            r_valid       <= 1'b0;
            r_result      <= '0;
            r_branchTo    <= '0;
            r_linkAddress <= '0;
        end else if (w_accept) begin
            r_valid       <= 1'b1;
            r_result      <= w_next;
            r_branchTo    <= w_target;
            r_linkAddress <= w_link;
        end else if (out_ready) begin
            r_valid       <= 1'b0;
            r_result      <= '0;
            r_branchTo    <= '0;
            r_linkAddress <= '0;
        end
    end

    assign out_valid      = r_valid;
    assign shouldUseNewPC = r_result.shouldUseNewPC;
    assign branchTo       = r_branchTo;
    assign linkValid      = r_result.linkValid;
    assign linkAddress    = r_linkAddress;
    assign rasMatch       = r_result.rasMatch;
    assign rasOverflow    = r_result.rasOverflow;
    assign rasUnderflow   = r_result.rasUnderflow;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: the driver predicts each accepted
// request with a queue-based reference model; a separate monitor compares
// whatever the DUT presents against the head of the expectation queue.
module tb_branch_resolver;
    import BranchModesPackage::*;

    localparam int AW    = 32;
    localparam int OW    = 16;
    localparam int JW    = 26;
    localparam int DEPTH = 8;

`ifdef BRANCH_RESOLVER_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    mode;
    logic [AW-1:0] pcAddress;
    logic [OW-1:0] branchAddressOffset;
    logic [JW-1:0] jumpAddress;
    logic [AW-1:0] jumpRegisterAddress;
    logic          resultZero;
    logic          resultNegative;
    logic          resultPositive;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic          shouldUseNewPC;
    logic [AW-1:0] branchTo;
    logic          linkValid;
    logic [AW-1:0] linkAddress;
    logic          rasMatch;
    logic          rasOverflow;
    logic          rasUnderflow;

    typedef struct {
        bit            newPc;
        logic [AW-1:0] target;
        bit            linkV;
        logic [AW-1:0] linkA;
        bit            match;
        bit            ovf;
        bit            unf;
    } exp_t;

    exp_t          expQ[$];
    logic [AW-1:0] rasModel[$];
    exp_t          monExp;
    bit            mValid;
    int            total;
    int            bad;

    branch_resolver #(
        .ADDR_W    (AW),
        .OFFSET_W  (OW),
        .JUMP_W    (JW),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .mode                (mode),
        .pcAddress           (pcAddress),
        .branchAddressOffset (branchAddressOffset),
        .jumpAddress         (jumpAddress),
        .jumpRegisterAddress (jumpRegisterAddress),
        .resultZero          (resultZero),
        .resultNegative      (resultNegative),
        .resultPositive      (resultPositive),
        .flush               (flush),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .shouldUseNewPC      (shouldUseNewPC),
        .branchTo            (branchTo),
        .linkValid           (linkValid),
        .linkAddress         (linkAddress),
        .rasMatch            (rasMatch),
        .rasOverflow         (rasOverflow),
        .rasUnderflow        (rasUnderflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: branch rules from the mode table, stack as a plain queue.
    task automatic modelResolve(input logic [3:0] m, input logic [AW-1:0] pc,
                                input logic [OW-1:0] off, input logic [JW-1:0] ja,
                                input logic [AW-1:0] jra, input bit z, input bit n,
                                input bit p, output exp_t e);
        bit            taken;
        logic [AW-1:0] tgt;
        logic signed [AW-1:0] offVal;
        e      = '{default: 0};
        offVal = $signed(off);
        tgt    = pc + AW'(offVal * 4);
        case (m)
            BranchMode_BEQ:                      taken = z;
            BranchMode_BNE:                      taken = !z;
            BranchMode_BGEZ, BranchMode_BGEZAL:  taken = z || p;
            BranchMode_BGTZ:                     taken = p;
            BranchMode_BLEZ:                     taken = z || n;
            BranchMode_BLTZ, BranchMode_BLTZAL:  taken = n;
            BranchMode_J, BranchMode_JAL: begin
                taken = 1;
                tgt   = (pc & 32'hF000_0000) | (AW'(ja) * 4);
            end
            BranchMode_JR, BranchMode_JALR: begin
                taken = 1;
                tgt   = jra;
            end
            default:                             taken = 0;
        endcase
        e.newPc  = taken;
        e.target = taken ? tgt : '0;
        if (m == BranchMode_JAL || m == BranchMode_JALR ||
            m == BranchMode_BGEZAL || m == BranchMode_BLTZAL) begin
            e.linkV = 1;
            e.linkA = pc + 8;
            if (rasModel.size() == DEPTH) begin
                void'(rasModel.pop_front());
                e.ovf = 1;
            end
            rasModel.push_back(pc + 8);
        end
        if (m == BranchMode_JR) begin
            if (rasModel.size() == 0) begin
                e.unf = 1;
            end else begin
                e.match = (rasModel[$] == jra);
                void'(rasModel.pop_back());
            end
        end
        e.match = e.match && RAS_ON;
        e.ovf   = e.ovf && RAS_ON;
        e.unf   = e.unf && RAS_ON;
    endtask

    // Drive one cycle of inputs, check handshake against the model, predict results.
    task automatic applyStimulus(input logic [3:0] m, input logic [AW-1:0] pc,
                                 input logic [OW-1:0] off, input logic [JW-1:0] ja,
                                 input logic [AW-1:0] jra, input logic [2:0] znp,
                                 input bit v, input bit rdy, input bit fl);
        bit   expIn;
        exp_t e;
        mode                = m;
        pcAddress           = pc;
        branchAddressOffset = off;
        jumpAddress         = ja;
        jumpRegisterAddress = jra;
        resultZero          = znp[2];
        resultNegative      = znp[1];
        resultPositive      = znp[0];
        in_valid            = v;
        out_ready           = rdy;
        flush               = fl;
        @(negedge clk);
        #1;
        expIn = !fl && (!mValid || rdy);
        checkOutput("in_ready", in_ready, expIn);
        checkOutput("out_valid", out_valid, mValid);
        if (fl) begin
            if (mValid && expQ.size() > 0) void'(expQ.pop_front());
            mValid = 0;
        end else if (v && expIn) begin
            modelResolve(m, pc, off, ja, jra, znp[2], znp[1], znp[0], e);
            expQ.push_back(e);
            mValid = 1;
        end else if (mValid && rdy) begin
            mValid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every presented result with the queue head; pop on hand-off.
    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_out_valid", out_valid, 1'b0);
            end else begin
                monExp = expQ[0];
                checkOutput("shouldUseNewPC", shouldUseNewPC, monExp.newPc);
                checkOutput("branchTo", branchTo, monExp.target);
                checkOutput("linkValid", linkValid, monExp.linkV);
                checkOutput("linkAddress", linkAddress, monExp.linkA);
                checkOutput("rasMatch", rasMatch, monExp.match);
                checkOutput("rasOverflow", rasOverflow, monExp.ovf);
                checkOutput("rasUnderflow", rasUnderflow, monExp.unf);
                if (out_ready) void'(expQ.pop_front());
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_shouldUseNewPC"}, shouldUseNewPC, 0);
        checkOutput({tag, "_branchTo"}, branchTo, 0);
        checkOutput({tag, "_linkValid"}, linkValid, 0);
        checkOutput({tag, "_linkAddress"}, linkAddress, 0);
        checkOutput({tag, "_rasMatch"}, rasMatch, 0);
        checkOutput({tag, "_rasOverflow"}, rasOverflow, 0);
        checkOutput({tag, "_rasUnderflow"}, rasUnderflow, 0);
    endtask

    initial begin
        logic [3:0]    rm;
        logic [AW-1:0] rjra;
        bit            rfl;
        total = 0;
        bad   = 0;
        mValid = 0;
        rst = 1'b0;
        in_valid = 0; out_ready = 0; flush = 0; mode = '0;
        pcAddress = '0; branchAddressOffset = '0; jumpAddress = '0; jumpRegisterAddress = '0;
        resultZero = 0; resultNegative = 0; resultPositive = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", in_ready, 1);

        // Directed cases: conditional, jump, link and return prediction
        applyStimulus(BranchMode_BEQ,  32'hAABBCCDD, 16'hFFFF, '0, '0, 3'b100, 1, 1, 0);
        applyStimulus(BranchMode_BEQ,  32'hAABBCCDD, 16'hFFFF, '0, '0, 3'b001, 1, 1, 0);
        applyStimulus(BranchMode_BLEZ, 32'hAABBCCDD, 16'h0FFF, '0, '0, 3'b010, 1, 1, 0);
        applyStimulus(BranchMode_J,    32'hAABBCCDD, '0, 26'hAABBCC, '0, 3'b000, 1, 1, 0);
        applyStimulus(BranchMode_JAL,  32'h00400000, '0, 26'h0100010, '0, 3'b000, 1, 1, 0);
        applyStimulus(BranchMode_JR,   32'h00500000, '0, '0, 32'h00400008, 3'b000, 1, 1, 0);

        // Stack overflow then underflow
        for (int i = 0; i <= DEPTH; i++)
            applyStimulus(BranchMode_JAL, 32'h1000 + 32'(i) * 256, '0, 26'(i), '0, 3'b000, 1, 1, 0);
        for (int i = DEPTH; i >= 0; i--)
            applyStimulus(BranchMode_JR, 32'h2000, '0, '0, 32'h1008 + 32'(i) * 256, 3'b000, 1, 1, 0);

        // Back-pressure hold, then flush of the held result
        applyStimulus(BranchMode_NONE, '0, '0, '0, '0, 3'b000, 0, 1, 0);
        applyStimulus(BranchMode_BGTZ, 32'h0000_1000, 16'h0010, '0, '0, 3'b001, 1, 0, 0);
        repeat (3) applyStimulus(BranchMode_JAL, 32'h3000, '0, '0, '0, 3'b000, 1, 0, 0);
        applyStimulus(BranchMode_JAL, 32'h3000, '0, '0, '0, 3'b000, 1, 0, 1);
        applyStimulus(BranchMode_JR, 32'h3100, '0, '0, 32'h3008, 3'b000, 1, 1, 0);

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            rm   = 4'($urandom_range(0, 12));
            rjra = $urandom;
            if (rm == BranchMode_JR && rasModel.size() > 0 && $urandom_range(0, 1) == 1)
                rjra = rasModel[$];
            rfl = ($urandom_range(0, 19) == 0);
            applyStimulus(rm, $urandom, 16'($urandom), 26'($urandom), rjra, 3'($urandom),
                          $urandom_range(0, 3) != 0, rfl ? 1'b0 : ($urandom_range(0, 3) != 0), rfl);
        end

        // Reset while a result is held, then a pop on the emptied stack
        applyStimulus(BranchMode_NONE, '0, '0, '0, '0, 3'b000, 0, 1, 0);
        applyStimulus(BranchMode_JAL, 32'h4000, '0, 26'h10, '0, 3'b000, 1, 0, 0);
        applyStimulus(BranchMode_NONE, '0, '0, '0, '0, 3'b000, 0, 0, 0);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("mid_reset");
        expQ.delete();
        rasModel.delete();
        mValid = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(BranchMode_JR, 32'h5000, '0, '0, 32'h4008, 3'b000, 1, 1, 0);

        // Drain
        repeat (3) applyStimulus(BranchMode_NONE, '0, '0, '0, '0, 3'b000, 0, 1, 0);
        checkOutput("queue_drained", 64'(expQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
